// File: rtl/proj_lane_pkg.sv
// rtl/proj_lane_pkg.sv - shared state encoding, default widths and saturating increment for the lane checker
package proj_lane_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    CHECK = 2'd1,
    LOST  = 2'd2
  } lane_state_e;

  localparam int DEF_W  = 16;
  localparam int DEF_EW = 8;
  localparam int DEF_X  = 2;
  localparam int DEF_L  = 4;

  // Increments v but holds at 2^w-1; callers size the result back down to w bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] top;
    top = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= top) ? top : v + 32'd1;
  endfunction

endpackage

// File: rtl/proj_lane_throttle.sv
// rtl/proj_lane_throttle.sv - fixed-duty ready throttle: registered rdy drops one cycle in every 2^X
module proj_lane_throttle #(
  parameter int X = 2
) (
  input  logic clk,
  input  logic rst,
  output logic rdy
);

  generate
    if (X == 0) begin : g_open
      always_ff @(posedge clk) begin
        if (!rst) rdy <= 1'b0;
        else      rdy <= 1'b1;
      end
    end else begin : g_duty
      logic [X-1:0] cnt;

      // rdy is low in the cycle after the counter sits at its terminal value.
      always_ff @(posedge clk) begin
        if (!rst) begin
          cnt <= '0;
          rdy <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
          rdy <= (cnt != '1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/proj_lane_chk.sv
// rtl/proj_lane_chk.sv - lane consumer checker: sequence lock, error/word counters, loss-of-lock tracking
// Optional first-error capture ports under PROJ_LANE_CHK_ERRCAP_EN.
module proj_lane_chk
  import proj_lane_pkg::*;
#(
  parameter int    W  = DEF_W,
  parameter int    EW = DEF_EW,
  parameter int    X  = DEF_X,
  parameter int    L  = DEF_L,
  parameter string ID = "LANE"
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld,
  input  logic [W-1:0]  data,
  output logic          rdy,
  output logic [EW-1:0] errcntr,
  output logic [31:0]   wrdcntr,
  output logic          locked,
  output logic          lost
`ifdef PROJ_LANE_CHK_ERRCAP_EN
  ,
  output logic [W-1:0]  errdata,
  output logic [W-1:0]  errexp,
  output logic          errvld
`endif
);

  lane_state_e  state;
  logic [W-1:0] exp_q;
  logic [3:0]   mm;
  logic         xfer;
  logic [W-1:0] data_inc;
  logic [3:0]   mm_inc;
  logic         miss;

  proj_lane_throttle #(.X(X)) u_throttle (
    .clk (clk),
    .rst (rst),
    .rdy (rdy)
  );

  assign xfer     = vld & rdy;
  assign data_inc = data + 1'b1;
  assign mm_inc   = mm + 4'd1;
  assign miss     = (data != exp_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= SYNC;
      exp_q   <= '0;
      mm      <= '0;
      errcntr <= '0;
      wrdcntr <= '0;
      locked  <= 1'b0;
      lost    <= 1'b0;
`ifdef PROJ_LANE_CHK_ERRCAP_EN
      errdata <= '0;
      errexp  <= '0;
      errvld  <= 1'b0;
`endif
    end else if (xfer) begin
      wrdcntr <= wrdcntr + 32'd1;
      // Every accepted word reseeds the expectation, so a single glitch costs one error.
      exp_q   <= data_inc;
      case (state)
        SYNC: begin
          state  <= CHECK;
          locked <= 1'b1;
        end
        CHECK: begin
          if (!miss) begin
            mm <= '0;
          end else begin
            errcntr <= EW'(sat_inc(32'(errcntr), EW));
`ifdef PROJ_LANE_CHK_ERRCAP_EN
            if (!errvld) begin
              errdata <= data;
              errexp  <= exp_q;
              errvld  <= 1'b1;
            end
`endif
            if (mm_inc == 4'(L)) begin
              state  <= LOST;
              locked <= 1'b0;
              lost   <= 1'b1;
              mm     <= '0;
            end else begin
              mm <= mm_inc;
            end
          end
        end
        LOST: begin
          if (!miss) begin
            state  <= CHECK;
            locked <= 1'b1;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst && xfer && state == CHECK && miss && mm_inc == 4'(L))
      $display("[%s] sequence lock lost at word %0d", ID, wrdcntr + 32'd1);
  end
`endif

endmodule

// File: tb/tb_proj_lane_chk.sv
// tb/tb_proj_lane_chk.sv - directed and random checks of proj_lane_chk against a behavioural lane model
module tb_proj_lane_chk;

  localparam int EMAX [2] = '{255, 3};
  localparam int PER  [2] = '{1, 4};
  localparam int LL       = 4;

  logic        clk;
  logic        rst_a, vld_a, rdy_a, locked_a, lost_a;
  logic [15:0] data_a;
  logic [7:0]  err_a;
  logic [31:0] wc_a;
  logic        rst_b, vld_b, rdy_b, locked_b, lost_b;
  logic [15:0] data_b;
  logic [1:0]  err_b;
  logic [31:0] wc_b;
`ifdef PROJ_LANE_CHK_ERRCAP_EN
  logic [15:0] ed_a, ee_a, ed_b, ee_b;
  logic        ev_a, ev_b;
`endif

  int n_asrt = 0;
  int n_fail = 0;
  bit took_a, took_b;

  // Behavioural model: mode 0 = seeking first word, 1 = checking, 2 = lock lost.
  int          m_mode [2];
  int          m_exp  [2];
  int          m_run  [2];
  int          m_err  [2];
  logic [31:0] m_wc   [2];
  bit          m_lk   [2];
  bit          m_ls   [2];
  int          m_k    [2];
  bit          m_cv   [2];
  int          m_cd   [2];
  int          m_ce   [2];

  proj_lane_chk #(.W(16), .EW(8), .X(0), .L(LL), .ID("LANE_A")) dut_a (
    .clk(clk), .rst(rst_a), .vld(vld_a), .data(data_a), .rdy(rdy_a),
    .errcntr(err_a), .wrdcntr(wc_a), .locked(locked_a), .lost(lost_a)
`ifdef PROJ_LANE_CHK_ERRCAP_EN
    , .errdata(ed_a), .errexp(ee_a), .errvld(ev_a)
`endif
  );

  proj_lane_chk #(.W(16), .EW(2), .X(2), .L(LL), .ID("LANE_B")) dut_b (
    .clk(clk), .rst(rst_b), .vld(vld_b), .data(data_b), .rdy(rdy_b),
    .errcntr(err_b), .wrdcntr(wc_b), .locked(locked_b), .lost(lost_b)
`ifdef PROJ_LANE_CHK_ERRCAP_EN
    , .errdata(ed_b), .errexp(ee_b), .errvld(ev_b)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void mreset(input int i);
    m_mode[i] = 0; m_exp[i] = 0; m_run[i] = 0; m_err[i] = 0; m_wc[i] = '0;
    m_lk[i] = 0; m_ls[i] = 0; m_k[i] = 0; m_cv[i] = 0; m_cd[i] = 0; m_ce[i] = 0;
  endfunction

  function automatic void mxfer(input int i, input int d);
    m_wc[i] = m_wc[i] + 32'd1;
    if (m_mode[i] == 0) begin
      m_mode[i] = 1; m_lk[i] = 1;
    end else if (m_mode[i] == 1) begin
      if (d == m_exp[i]) m_run[i] = 0;
      else begin
        if (m_err[i] < EMAX[i]) m_err[i]++;
        if (!m_cv[i]) begin m_cv[i] = 1; m_cd[i] = d; m_ce[i] = m_exp[i]; end
        m_run[i]++;
        if (m_run[i] == LL) begin m_mode[i] = 2; m_lk[i] = 0; m_ls[i] = 1; m_run[i] = 0; end
      end
    end else if (d == m_exp[i]) begin
      m_mode[i] = 1; m_lk[i] = 1;
    end
    m_exp[i] = (d + 1) % 65536;
  endfunction

  // Cycle k after reset release: ready unless the previous cycle's count was 2^X-1.
  function automatic bit mrdy(input int i);
    if (m_k[i] == 0) return 1'b0;
    if (PER[i] == 1) return 1'b1;
    return ((m_k[i] - 1) % PER[i]) != (PER[i] - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge with inputs already set; advances one clock and compares both lanes.
  task automatic tick();
    bit ta, tb;
    ta = rst_a && vld_a && rdy_a;
    tb = rst_b && vld_b && rdy_b;
    @(posedge clk);
    if (!rst_a) mreset(0); else begin m_k[0]++; if (ta) mxfer(0, int'(data_a)); end
    if (!rst_b) mreset(1); else begin m_k[1]++; if (tb) mxfer(1, int'(data_b)); end
    took_a = ta;
    took_b = tb;
    @(negedge clk);
    chk("a.rdy", rdy_a, mrdy(0));
    chk("a.errcntr", err_a, m_err[0]);
    chk("a.wrdcntr", wc_a, m_wc[0]);
    chk("a.locked", locked_a, m_lk[0]);
    chk("a.lost", lost_a, m_ls[0]);
    chk("b.rdy", rdy_b, mrdy(1));
    chk("b.errcntr", err_b, m_err[1]);
    chk("b.wrdcntr", wc_b, m_wc[1]);
    chk("b.locked", locked_b, m_lk[1]);
    chk("b.lost", lost_b, m_ls[1]);
`ifdef PROJ_LANE_CHK_ERRCAP_EN
    chk("a.errvld", ev_a, m_cv[0]);
    chk("a.errdata", ed_a, m_cd[0]);
    chk("a.errexp", ee_a, m_ce[0]);
    chk("b.errvld", ev_b, m_cv[1]);
    chk("b.errdata", ed_b, m_cd[1]);
    chk("b.errexp", ee_b, m_ce[1]);
`endif
  endtask

  task automatic send_a(input int d);
    int n = 0;
    vld_a = 1'b1;
    data_a = 16'(d);
    do begin tick(); n++; end while (!took_a && n < 8);
    chk("a.accepted", took_a, 1);
  endtask

  task automatic send_b(input int d);
    int n = 0;
    vld_b = 1'b1;
    data_b = 16'(d);
    do begin tick(); n++; end while (!took_b && n < 8);
    chk("b.accepted", took_b, 1);
  endtask

  task automatic reset_a();
    vld_a = 1'b0; rst_a = 1'b0; tick(); rst_a = 1'b1;
  endtask

  task automatic reset_b();
    vld_b = 1'b0; rst_b = 1'b0; tick(); rst_b = 1'b1;
  endtask

  initial begin
    int src, cnt;
    rst_a = 1'b0; vld_a = 1'b0; data_a = '0;
    rst_b = 1'b0; vld_b = 1'b0; data_b = '0;
    mreset(0); mreset(1);
    @(negedge clk);
    tick(); tick();
    chk("reset.rdy", rdy_a, 0);
    chk("reset.errcntr", err_a, 0);
    chk("reset.wrdcntr", wc_b, 0);
    chk("reset.locked", locked_b, 0);
    chk("reset.lost", lost_a, 0);
    rst_a = 1'b1; rst_b = 1'b1;

    // Clean incrementing stream, ready always high.
    for (int i = 0; i < 256; i++) send_a(5 + i);
    vld_a = 1'b0; tick();
    chk("clean.errcntr", err_a, 0);
    chk("clean.wrdcntr", wc_a, 256);
    chk("clean.locked", locked_a, 1);
    chk("clean.lost", lost_a, 0);

    reset_a();
    send_a(16'hFFFE); send_a(16'hFFFF); send_a(16'h0000); send_a(16'h0001);
    chk("wrap.errcntr", err_a, 0);
    chk("wrap.locked", locked_a, 1);

    reset_a();
    send_a(10); send_a(11); send_a(99);
    chk("glitch.err_after_99", err_a, 1);
    send_a(100); send_a(101);
    chk("glitch.errcntr", err_a, 1);
    chk("glitch.locked", locked_a, 1);

    reset_a();
    send_a(40); send_a(50); send_a(70); send_a(90); send_a(110);
    chk("loss.locked", locked_a, 0);
    chk("loss.lost", lost_a, 1);
    chk("loss.errcntr", err_a, 4);
    send_a(111);
    chk("relock.locked", locked_a, 1);
    chk("relock.lost", lost_a, 1);

    reset_a();
    for (int i = 0; i < 400; i++) begin
      vld_a = ($urandom_range(0, 3) != 0);
      data_a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(m_exp[0]);
      tick();
    end
    vld_a = 1'b0;

    // Throttled lane: source advances only on an accepted word.
    reset_b();
    vld_b = 1'b1; src = 16'h1234; cnt = 0;
    for (int i = 0; i < 40; i++) begin
      data_b = 16'(src);
      tick();
      if (took_b) begin src++; cnt++; end
    end
    chk("throttle.transfers", cnt, 30);
    chk("throttle.errcntr", err_b, 0);
    chk("throttle.locked", locked_b, 1);

    for (int r = 0; r < 6; r++) begin
      send_b(src + 5); src = src + 6;
      send_b(src); src = src + 1;
    end
    chk("sat.errcntr", err_b, 3);
    chk("sat.lost", lost_b, 0);
    for (int r = 0; r < 4; r++) begin
      send_b(src + 7); src = src + 8;
    end
    chk("sat.hold", err_b, 3);
    chk("sat.lost_after_run", lost_b, 1);
    chk("sat.locked_after_run", locked_b, 0);

    vld_b = 1'b1; data_b = 16'(src);
    rst_b = 1'b0; tick(); rst_b = 1'b1;
    chk("midrst.errcntr", err_b, 0);
    chk("midrst.wrdcntr", wc_b, 0);
    chk("midrst.lost", lost_b, 0);
    chk("midrst.rdy", rdy_b, 0);
    send_b(int'($urandom_range(0, 65535)));
    chk("reseed.locked", locked_b, 1);
    chk("reseed.errcntr", err_b, 0);
    chk("reseed.wrdcntr", wc_b, 1);
    vld_b = 1'b0; tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
